uart_cmd_decoder: RTL and testbench
===================================

// Module: uart_cmd_decoder
// PURPOSE
//  Receive-side command path: turns ASCII text arriving from the UART receiver
//  (uart_top o_rx_data/o_rx_valid) into 8-bit sequencer instructions. It is the
//  host-driven counterpart of the button/switch instruction path.
//  - Parses lines of two hex digits plus CR/LF.
//  - Buffers decoded words in a small FIFO.
//  - Issues them as single-cycle i_inst/i_inst_valid strobes, with a minimum
//    gap between strobes so the sequencer and UART TX can drain.
// PARAMETERS
//  FIFO_AW   2   log2 FIFO depth (default depth 4)
//  INST_GAP  16  minimum clk cycles between o_inst_valid rising edges (>=1)
//  ERR_W     8   width of saturating error counter
// PORTS
//  clk          in   1        system clock (100MHz)
//  rst_n        in   1        asynchronous active-low reset
//  i_rx_data    in   8        received byte, qualified by i_rx_valid
//  i_rx_valid   in   1        1-cycle strobe per received byte
//  o_inst       out  8        instruction word to sequencer
//  o_inst_valid out  1        1-cycle issue strobe
//  o_err        out  1        1-cycle pulse per parse error or FIFO overflow
//  o_err_cnt    out  ERR_W    saturating error count
//  o_fifo_cnt   out  FIFO_AW+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, FSM=S_IDLE, FIFO empty, gap timer 0.
//  A partial line is discarded. Reset takes effect immediately, mid-line or mid-gap.
//  Byte classes (sampled only when i_rx_valid=1):
//  - HEX: 0x30-0x39, 0x41-0x46, 0x61-0x66 (case-insensitive).
//  - EOL: 0x0D or 0x0A.
//  - OTHER: any remaining byte.
//  Parser FSM, one transition per strobe:
//  - S_IDLE: HEX -> hi nibble, S_HI. EOL -> stay (empty line; makes CRLF legal).
//    OTHER -> err, S_ERR.
//  - S_HI: HEX -> lo nibble, S_LO. EOL -> err, S_IDLE. OTHER -> err, S_ERR.
//  - S_LO: EOL -> push {hi,lo}, S_IDLE. HEX/OTHER -> err, S_ERR.
//  - S_ERR: EOL -> S_IDLE. Other bytes are ignored, with no further err pulses.
//  Push into a full FIFO drops the word and raises err.
//  - Fullness is judged before any same-cycle pop, so a push with a same-cycle
//    pop while full is still dropped.
//  err is registered:
//  - o_err is high the cycle after the offending strobe.
//  - o_err_cnt increments in that same cycle and saturates at 2^ERR_W-1.
//  FIFO:
//  - Written at the clock edge that samples the EOL strobe.
//  - Simultaneous push and pop (not full) leaves the count unchanged.
//  - o_fifo_cnt is registered.
//  Issue logic:
//  - Fires when the FIFO is non-empty and the gap timer is 0.
//  - o_inst_valid=1 for exactly one cycle; o_inst=head word; head popped.
//  - Gap timer loaded with INST_GAP-1 and decremented to 0.
//  - o_inst holds its last value between strobes.
//  Latency: an EOL strobe in cycle N, with the FIFO empty and the gap idle,
//  gives o_inst_valid in cycle N+2.
//  Spacing: consecutive o_inst_valid pulses are exactly INST_GAP cycles apart
//  while the FIFO stays non-empty.
//  No other backpressure; i_rx_valid may assert on consecutive cycles.
// TESTING
//  1. "3A\r\n" -> single o_inst_valid with o_inst=0x3A, 2 cycles after the '\r'
//     strobe; '\n' ignored; o_err_cnt=0.
//  2. "c5\n" -> o_inst=0xC5 (lowercase accepted); o_err never pulses.
//  3. "3G\n" then "01\n" -> one o_err pulse, o_err_cnt=1, no issue for the first
//     line; then o_inst=0x01.
//  4. "123\n" then "1\n" -> two err pulses, o_err_cnt=2, no o_inst_valid.
//  5. Lines "00\n".."05\n", strobes on consecutive cycles, INST_GAP=16, depth 4:
//     - 0x00..0x04 issued exactly 16 cycles apart.
//     - 0x05 dropped, o_err_cnt=1, o_fifo_cnt peaks at 4.
//  6. Pulse rst_n low after "A" with 2 words queued; then send "5\n" ->
//     - FIFO flushed, o_err_cnt=0, nothing issued.
//     - Then one err (EOL in S_HI), still nothing issued.
//     - Also drive 300 bad lines -> o_err_cnt stays at 255.

Source files
------------

// File: rtl/uart_cmd_decoder_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_decoder_if
// Byte-in / instruction-out handshake bundle for uart_cmd_decoder.
//   rx_data    [7:0]  received byte from the UART receiver
//   rx_valid          1-cycle strobe qualifying rx_data
//   inst       [7:0]  instruction word to the sequencer
//   inst_valid        1-cycle issue strobe for inst
// Modports:
//   slave  - the decoder (consumes rx bytes, produces instructions)
//   master - the UART/sequencer side (or a testbench)
// ---------------------------------------------------------------------------
interface uart_cmd_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] inst;
    logic       inst_valid;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output inst,
        output inst_valid
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  inst,
        input  inst_valid
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// ---------------------------------------------------------------------------
// uart_cmd_decoder
// Turns ASCII lines of two hex digits terminated by CR and/or LF into 8-bit
// sequencer instructions. Decoded words are buffered in a small FIFO and
// issued as single-cycle strobes with a minimum spacing of INST_GAP cycles.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   cmd         uart_cmd_decoder_if.slave: rx_data/rx_valid in,
//               inst/inst_valid out
//   o_err       1-cycle pulse per parse error or FIFO overflow
//   o_err_cnt   saturating error count
//   o_fifo_cnt  current FIFO occupancy (registered)
// ---------------------------------------------------------------------------
module uart_cmd_decoder #(
    parameter int unsigned FIFO_AW  = 2,
    parameter int unsigned INST_GAP = 16,
    parameter int unsigned ERR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_cmd_decoder_if.slave    cmd,
    output logic                 o_err,
    output logic [ERR_W-1:0]     o_err_cnt,
    output logic [FIFO_AW:0]     o_fifo_cnt
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned GAP_W = (INST_GAP > 1) ? $clog2(INST_GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_ERR
    } state_t;

    // ---------------- byte classification ----------------
    logic       is_hex;
    logic       is_eol;
    logic [3:0] nib;

    always_comb begin
        is_hex = 1'b0;
        nib    = '0;
        is_eol = (cmd.rx_data == 8'h0D) || (cmd.rx_data == 8'h0A);
        if (cmd.rx_data >= 8'h30 && cmd.rx_data <= 8'h39) begin
            is_hex = 1'b1;
            nib    = cmd.rx_data[3:0];
        end else if ((cmd.rx_data >= 8'h41 && cmd.rx_data <= 8'h46) ||
                     (cmd.rx_data >= 8'h61 && cmd.rx_data <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them to 10..15
            is_hex = 1'b1;
            nib    = cmd.rx_data[3:0] + 4'd9;
        end
    end

    // ---------------- parser FSM ----------------
    state_t     state_q, state_d;
    logic [3:0] hi_q, hi_d;
    logic [3:0] lo_q, lo_d;
    logic       parse_err;
    logic       push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        parse_err = 1'b0;
        push      = 1'b0;
        if (cmd.rx_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_hex) begin
                        hi_d    = nib;
                        state_d = S_HI;
                    end else if (!is_eol) begin
                        parse_err = 1'b1;
                        state_d   = S_ERR;
                    end
                end
                S_HI: begin
                    if (is_hex) begin
                        lo_d    = nib;
                        state_d = S_LO;
                    end else begin
                        parse_err = 1'b1;
                        state_d   = is_eol ? S_IDLE : S_ERR;
                    end
                end
                S_LO: begin
                    if (is_eol) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        parse_err = 1'b1;
                        state_d   = S_ERR;
                    end
                end
                S_ERR: begin
                    if (is_eol) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q;
    logic               full;
    logic               empty;
    logic               wr_en;
    logic               overflow;
    logic               fire;

    // Occupancy never exceeds DEPTH, so the MSB alone marks full.
    // Fullness uses the registered count, so a same-cycle pop never makes
    // room for a push.
    assign full     = cnt_q[FIFO_AW];
    assign empty    = (cnt_q == '0);
    assign wr_en    = push && !full;
    assign overflow = push && full;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {hi_q, lo_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fire)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({wr_en, fire})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign o_fifo_cnt = cnt_q;

    // ---------------- issue logic ----------------
    logic [GAP_W-1:0] gap_q;
    logic             inst_valid_q;
    logic [7:0]       inst_q;

    assign fire = !empty && (gap_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q        <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
        end else begin
            inst_valid_q <= fire;
            if (fire) begin
                inst_q <= mem_q[rd_ptr_q];
                gap_q  <= GAP_W'(INST_GAP - 1);
            end else if (gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end
        end
    end

    assign cmd.inst       = inst_q;
    assign cmd.inst_valid = inst_valid_q;

    // ---------------- error reporting ----------------
    logic             err_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic             err_d;

    assign err_d = parse_err || overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= err_d;
            if (err_d && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign o_err     = err_q;
    assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_decoder
// Directed testbench for uart_cmd_decoder (FIFO_AW=2, INST_GAP=16, ERR_W=8).
// Bytes are driven one per cycle just after the rising edge; a negedge
// monitor records every issued instruction with its cycle number, counts
// o_err pulses and tracks the peak FIFO occupancy.
// ---------------------------------------------------------------------------
module tb_uart_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       o_err;
    logic [7:0] o_err_cnt;
    logic [2:0] o_fifo_cnt;

    uart_cmd_decoder_if cmd_if ();

    uart_cmd_decoder #(
        .FIFO_AW (2),
        .INST_GAP(16),
        .ERR_W   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_if.slave),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt),
        .o_fifo_cnt(o_fifo_cnt)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         err_pulses = 0;
    int         fifo_max = 0;
    int         ev_cyc[$];
    logic [7:0] ev_dat[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_if.inst_valid === 1'b1) begin
            ev_cyc.push_back(cyc);
            ev_dat.push_back(cmd_if.inst);
        end
        if (o_err === 1'b1) err_pulses++;
        if (int'(o_fifo_cnt) > fifo_max) fifo_max = int'(o_fifo_cnt);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev_d(input int i);
        return (ev_dat.size() > i) ? {24'h0, ev_dat[i]} : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ev_c(input int i);
        return (ev_cyc.size() > i) ? ev_cyc[i] : 32'hFFFF_FFFF;
    endfunction

    // Entered and left at posedge+1; one byte strobe per cycle.
    task automatic send_byte(input logic [7:0] b);
        cmd_if.rx_data  = b;
        cmd_if.rx_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        cmd_if.rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic assert_rst();
        cmd_if.rx_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1 rst_n = 1'b1;
        ev_cyc.delete();
        ev_dat.delete();
        err_pulses = 0;
        fifo_max   = 0;
    endtask

    task automatic do_reset();
        assert_rst();
        release_rst();
    endtask

    int eol_cyc;
    int eol0_cyc;

    initial begin
        cmd_if.rx_data  = 8'h00;
        cmd_if.rx_valid = 1'b0;
        #12 rst_n = 1'b0;
        check("rst_inst_valid", {31'h0, cmd_if.inst_valid}, 32'h0);
        check("rst_inst", {24'h0, cmd_if.inst}, 32'h0);
        check("rst_err", {31'h0, o_err}, 32'h0);
        check("rst_err_cnt", {24'h0, o_err_cnt}, 32'h0);
        check("rst_fifo_cnt", {29'h0, o_fifo_cnt}, 32'h0);
        release_rst();

        // 1: "3A\r\n"
        send_str("3A");
        eol_cyc = cyc;
        send_byte(8'h0D);
        send_byte(8'h0A);
        idle(25);
        check("t1_count", ev_cyc.size(), 1);
        check("t1_data", ev_d(0), 32'h3A);
        check("t1_latency", ev_c(0), eol_cyc + 2);
        check("t1_err_cnt", {24'h0, o_err_cnt}, 32'h0);
        check("t1_err_pulses", err_pulses, 0);

        // 2: lowercase "c5\n"
        do_reset();
        send_str("c5\n");
        idle(25);
        check("t2_count", ev_cyc.size(), 1);
        check("t2_data", ev_d(0), 32'hC5);
        check("t2_err_pulses", err_pulses, 0);
        check("t2_inst_hold", {24'h0, cmd_if.inst}, 32'hC5);

        // 3: "3G\n" then "01\n"
        do_reset();
        send_str("3G\n01\n");
        idle(40);
        check("t3_err_pulses", err_pulses, 1);
        check("t3_err_cnt", {24'h0, o_err_cnt}, 32'h1);
        check("t3_count", ev_cyc.size(), 1);
        check("t3_data", ev_d(0), 32'h01);

        // 4: "123\n" then "1\n"
        do_reset();
        send_str("123\n1\n");
        idle(40);
        check("t4_err_pulses", err_pulses, 2);
        check("t4_err_cnt", {24'h0, o_err_cnt}, 32'h2);
        check("t4_count", ev_cyc.size(), 0);

        // 5: "00\n".."05\n" back to back, sixth line overflows
        do_reset();
        eol0_cyc = 0;
        for (int k = 0; k < 6; k++) begin
            send_byte(8'h30);
            send_byte(8'h30 + 8'(k));
            if (k == 0) eol0_cyc = cyc;
            send_byte(8'h0A);
        end
        idle(100);
        check("t5_count", ev_cyc.size(), 5);
        check("t5_latency", ev_c(0), eol0_cyc + 2);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t5_data%0d", k), ev_d(k), k);
            if (k > 0)
                check($sformatf("t5_gap%0d", k), ev_c(k) - ev_c(k - 1), 16);
        end
        check("t5_err_cnt", {24'h0, o_err_cnt}, 32'h1);
        check("t5_err_pulses", err_pulses, 1);
        check("t5_fifo_max", fifo_max, 4);
        check("t5_fifo_end", {29'h0, o_fifo_cnt}, 32'h0);

        // 6: reset mid-line with two words queued and the gap running
        do_reset();
        send_str("11\n22\n33\nA");
        check("t6_queued", {29'h0, o_fifo_cnt}, 32'h2);
        assert_rst();
        check("t6_rst_fifo", {29'h0, o_fifo_cnt}, 32'h0);
        check("t6_rst_err_cnt", {24'h0, o_err_cnt}, 32'h0);
        check("t6_rst_valid", {31'h0, cmd_if.inst_valid}, 32'h0);
        check("t6_rst_inst", {24'h0, cmd_if.inst}, 32'h0);
        release_rst();
        send_str("5\n");
        idle(40);
        check("t6_err_pulses", err_pulses, 1);
        check("t6_err_cnt", {24'h0, o_err_cnt}, 32'h1);
        check("t6_count", ev_cyc.size(), 0);
        for (int i = 0; i < 300; i++) send_str("G\n");
        idle(5);
        check("t6_err_sat", {24'h0, o_err_cnt}, 32'hFF);
        check("t6_err_pulses_all", err_pulses, 301);
        check("t6_count_end", ev_cyc.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
